// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage.
// Also holds the EX/MEM control-bit positions used by stages that decode ctrl.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 4;
  localparam int DEF_RD_W   = 5;
  localparam int DEF_CNT_W  = 16;

  // Bit positions inside the EX/MEM control field.
  localparam int CTRL_MEM_WRITE    = 0;
  localparam int CTRL_MEM_READ     = 1;
  localparam int CTRL_WBSEL        = 2;
  localparam int CTRL_REG_WRITE_EN = 3;

  function automatic logic state_can_accept(input pipe_state_t s);
    return s != SKID;
  endfunction

  function automatic logic state_has_entry(input pipe_state_t s);
    return s != EMPTY;
  endfunction

endpackage

// File: rtl/pipe_slot_reg.sv
// One {data, ctrl, rd} holding register with load and clear.
// Clear wins over load so a kill never lets a new entry slip in.
module pipe_slot_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int RD_W   = DEF_RD_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [RD_W-1:0]   load_rd,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [RD_W-1:0]   rd
);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      data <= '0;
      ctrl <= '0;
      rd   <= '0;
    end else if (load) begin
      data <= load_data;
      ctrl <= load_ctrl;
      rd   <= load_rd;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with main+skid storage and a registered in_ready.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int RD_W   = DEF_RD_W
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W  = DEF_CNT_W
`endif
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  pipe_state_t state, next_state;

  logic accept;
  logic main_load, main_from_skid, main_clear, skid_load;

  logic [DATA_W-1:0] skid_data, main_load_data;
  logic [CTRL_W-1:0] skid_ctrl, main_load_ctrl;
  logic [RD_W-1:0]   skid_rd,   main_load_rd;

  assign accept = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      next_state = EMPTY;
      main_clear = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            next_state = FULL;
            main_load  = 1'b1;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (accept) begin
              main_load = 1'b1;
            end else begin
              // Draining to empty also clears ctrl/rd so bubbles carry no control.
              next_state = EMPTY;
              main_clear = 1'b1;
            end
          end else if (accept) begin
            next_state = SKID;
            skid_load  = 1'b1;
          end
        end
        SKID: begin
          if (out_ready) begin
            next_state     = FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          next_state = EMPTY;
          main_clear = 1'b1;
        end
      endcase
    end
  end

  // State plus handshake outputs, all registered from the next state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= state_can_accept(next_state);
      out_valid <= state_has_entry(next_state);
    end
  end

  assign main_load_data = main_from_skid ? skid_data : in_data;
  assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_load_rd   = main_from_skid ? skid_rd   : in_rd;

  pipe_slot_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .RD_W   (RD_W)
  ) u_main (
    .CLK       (CLK),
    .reset     (reset),
    .clear     (main_clear),
    .load      (main_load),
    .load_data (main_load_data),
    .load_ctrl (main_load_ctrl),
    .load_rd   (main_load_rd),
    .data      (out_data),
    .ctrl      (out_ctrl),
    .rd        (out_rd)
  );

  pipe_slot_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .RD_W   (RD_W)
  ) u_skid (
    .CLK       (CLK),
    .reset     (reset),
    .clear     (flush),
    .load      (skid_load),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .load_rd   (in_rd),
    .data      (skid_data),
    .ctrl      (skid_ctrl),
    .rd        (skid_rd)
  );

`ifdef PIPE_STAGE_PERF_EN
  // Counters saturate at all-ones; flush leaves them untouched.
  always_ff @(posedge CLK) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!out_valid && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
